fifo_share_arbiter: RTL and testbench



---
 rtl/fifo_share_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_share_arbiter.sv
// Round-robin arbiter with burst locking in front of one bypass-FIFO enqueue port.
// Optional per-requester beat counters: define FIFO_SHARE_ARBITER_STATS_EN.
module fifo_share_arbiter #(
  parameter int N     = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*N-1:0]         req_data,
  output logic [NREQ-1:0]           grant,
  input  logic                      fifo_full,
  output logic                      fifo_we,
  output logic [N-1:0]              fifo_wdata,
  output logic [$clog2(NREQ)-1:0]   owner
`ifdef FIFO_SHARE_ARBITER_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NREQ*16-1:0]        gnt_cnt
`endif
);

  localparam int          IW = $clog2(NREQ);
  localparam int          CW = $clog2(BURST + 1);
  localparam int unsigned NR = NREQ;
  localparam int unsigned NW = N;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   base;
  logic [IW-1:0]   win;
  logic            found;
  logic [IW-1:0]   idx;

  // A dropped owner is scanned from its own index so it cannot re-win first.
  always_comb begin
    base  = (state_q == LOCK && !req[own_q]) ? own_q : ptr_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = IW'((32'(base) + k) % NR);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    if (rst_n && !fifo_full) begin
      if (state_q == LOCK && req[own_q]) begin
        gnt[own_q] = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        if (32'(cnt_q) + 32'd1 == 32'(BURST)) begin
          state_d = IDLE;
          ptr_d   = own_q;
        end
      end else begin
        state_d = IDLE;
        if (state_q == LOCK) ptr_d = own_q;
        if (found) begin
          gnt[win] = 1'b1;
          ptr_d    = win;
          own_d    = win;
          cnt_d    = CW'(1);
          state_d  = (BURST > 1) ? LOCK : IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      own_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant   = gnt;
  assign fifo_we = |gnt;
  assign owner   = own_q;

  always_comb begin
    fifo_wdata = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt[i]) fifo_wdata = req_data[i*NW +: N];
    end
  end

`ifdef FIFO_SHARE_ARBITER_STATS_EN
  logic [15:0] gcnt_q [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR; i++) gcnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (stats_clr)
          gcnt_q[i] <= '0;
        else if (gnt[i] && gcnt_q[i] != '1)
          gcnt_q[i] <= gcnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    gnt_cnt = '0;
    for (int unsigned i = 0; i < NR; i++) gnt_cnt[i*16 +: 16] = gcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_share_arbiter.sv
// Scoreboard bench for fifo_share_arbiter: BURST=4 instance plus a BURST=1 instance.
module tb_fifo_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic         fifo_full;
  logic [3:0]   grant, grant1;
  logic         fifo_we, fifo_we1;
  logic [31:0]  fifo_wdata, fifo_wdata1;
  logic [1:0]   owner, owner1;
`ifdef FIFO_SHARE_ARBITER_STATS_EN
  logic         stats_clr;
  logic [63:0]  gnt_cnt, gnt_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  gnt;
    logic        we;
    logic [31:0] wd;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fifo_share_arbiter #(.N(32), .NREQ(4), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_wdata(fifo_wdata), .owner(owner)
`ifdef FIFO_SHARE_ARBITER_STATS_EN
    , .stats_clr(stats_clr), .gnt_cnt(gnt_cnt)
`endif
  );

  fifo_share_arbiter #(.N(32), .NREQ(4), .BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant1),
    .fifo_full(fifo_full), .fifo_we(fifo_we1), .fifo_wdata(fifo_wdata1), .owner(owner1)
`ifdef FIFO_SHARE_ARBITER_STATS_EN
    , .stats_clr(stats_clr), .gnt_cnt(gnt_cnt1)
`endif
  );

  function automatic logic [31:0] exp_data(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 32'hA0 + 32'h11 * i;
    return 32'h0;
  endfunction

  task automatic drive(input logic [3:0] r, input logic f, input logic [3:0] eg);
    exp_t e;
    req       = r;
    fifo_full = f;
    e.gnt = eg;
    e.we  = |eg;
    e.wd  = exp_data(eg);
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    req       = 4'b0000;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    fifo_full = 1'b0;
    #12;
    n_cmp++;
    if ({grant, fifo_we, owner, fifo_wdata} !== {4'b0, 1'b0, 2'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset: got grant=%b we=%b owner=%0d wdata=%h, want 0/0/0/0",
               grant, fifo_we, owner, fifo_wdata);
    end
    n_cmp++;
    if ({grant1, fifo_we1, owner1} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_b1: got grant=%b we=%b owner=%0d, want 0/0/0", grant1, fifo_we1, owner1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    exp_t e;
    for (int k = 0; k < 18; k++) begin
      if (k < 17) drive(4'b1111, 1'b0, 4'b0001 << ((k / 4) % 4));
      else        drive(4'b0000, 1'b0, 4'b0000);
      @(negedge clk);
      e = sbq.pop_front();
      n_cmp++;
      if ({grant, fifo_we, fifo_wdata} !== {e.gnt, e.we, e.wd}) begin
        n_bad++;
        $display("FAIL round_robin[%0d]: got grant=%b we=%b wdata=%h, want grant=%b we=%b wdata=%h",
                 k, grant, fifo_we, fifo_wdata, e.gnt, e.we, e.wd);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [3:0] eg [7];
    logic       ff [7];
    eg = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
    ff = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(4'b0101, ff[k], eg[k]);
      @(negedge clk);
      e = sbq.pop_front();
      n_cmp++;
      if ({grant, fifo_we, fifo_wdata} !== {e.gnt, e.we, e.wd}) begin
        n_bad++;
        $display("FAIL stall[%0d]: got grant=%b we=%b wdata=%h, want grant=%b we=%b wdata=%h",
                 k, grant, fifo_we, fifo_wdata, e.gnt, e.we, e.wd);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_release();
    exp_t e;
    logic [3:0] rq [7];
    logic [3:0] eg [7];
    rq = '{4'b0010, 4'b0010, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
    eg = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(rq[k], 1'b0, eg[k]);
      @(negedge clk);
      e = sbq.pop_front();
      n_cmp++;
      if ({grant, fifo_we, fifo_wdata} !== {e.gnt, e.we, e.wd}) begin
        n_bad++;
        $display("FAIL release[%0d]: got grant=%b we=%b wdata=%h, want grant=%b we=%b wdata=%h",
                 k, grant, fifo_we, fifo_wdata, e.gnt, e.we, e.wd);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b0, (k < 4) ? 4'b0001 : (k < 6) ? 4'b0010 : (k == 6) ? 4'b0010 : 4'b0001);
      if (k == 6) begin
        #1;
        e = sbq.pop_front();
        n_cmp++;
        if ({grant, fifo_we} !== {e.gnt, e.we}) begin
          n_bad++;
          $display("FAIL pre_abort: got grant=%b we=%b, want grant=%b we=%b", grant, fifo_we, e.gnt, e.we);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant, fifo_we, owner, fifo_wdata} !== 39'b0) begin
          n_bad++;
          $display("FAIL abort: got grant=%b we=%b owner=%0d wdata=%h, want 0/0/0/0",
                   grant, fifo_we, owner, fifo_wdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        continue;
      end
      @(negedge clk);
      e = sbq.pop_front();
      n_cmp++;
      if ({grant, fifo_we, fifo_wdata} !== {e.gnt, e.we, e.wd}) begin
        n_bad++;
        $display("FAIL reset_mid[%0d]: got grant=%b we=%b wdata=%h, want grant=%b we=%b wdata=%h",
                 k, grant, fifo_we, fifo_wdata, e.gnt, e.we, e.wd);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_burst1();
    exp_t e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b1001, 1'b0, (k % 2 == 0) ? 4'b0001 : 4'b1000);
      @(negedge clk);
      e = sbq.pop_front();
      n_cmp++;
      if ({grant1, fifo_we1, fifo_wdata1} !== {e.gnt, e.we, e.wd}) begin
        n_bad++;
        $display("FAIL burst1[%0d]: got grant=%b we=%b wdata=%h, want grant=%b we=%b wdata=%h",
                 k, grant1, fifo_we1, fifo_wdata1, e.gnt, e.we, e.wd);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef FIFO_SHARE_ARBITER_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b0;
    do_reset();
    req = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt_cnt[15:0] !== 16'd5) begin
      n_bad++;
      $display("FAIL stats_count: got %0d, want 5", gnt_cnt[15:0]);
    end
    repeat (70000) @(posedge clk);
    #1;
    n_cmp++;
    if (gnt_cnt !== {48'h0, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL stats_sat: got %h, want %h", gnt_cnt, {48'h0, 16'hFFFF});
    end
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    n_cmp++;
    if (gnt_cnt[15:0] !== 16'h0) begin
      n_bad++;
      $display("FAIL stats_clr: got %h, want 0000", gnt_cnt[15:0]);
    end
    req = 4'b0000;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0 + 32'h11 * i;
`ifdef FIFO_SHARE_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_stall();
    test_release();
    test_reset_mid_burst();
    test_burst1();
`ifdef FIFO_SHARE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
